mult_share_arbiter: RTL and testbench



---
 rtl/mult_arb_pkg.sv | 19 +
 rtl/mult_tag_pipe.sv | 27 ++
 rtl/mult_share_arbiter.sv | 119 +++++++++++
 tb/tb_mult_share_arbiter.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mult_arb_pkg.sv
// Shared types and helpers for the multiplier-sharing arbiter: tag struct,
// id width and the round-robin pointer advance.
package mult_arb_pkg;

    localparam int unsigned MAX_NREQ = 4;
    localparam int unsigned IDW      = $clog2(MAX_NREQ);

    typedef struct packed {
        logic           vld;
        logic [IDW-1:0] id;
    } tag_t;

    // Pointer to the index after the grant, wrapping at nreq-1.
    function automatic logic [IDW-1:0] rr_next(input logic [IDW-1:0] g, input int unsigned nreq);
        if (32'(g) + 32'd1 >= nreq) return '0;
        return g + 1'b1;
    endfunction

endpackage

// File: rtl/mult_tag_pipe.sv
// Delay line of {vld, id} tags that tracks operations in flight through the
// shared multiplier; synchronous clear discards everything in flight.
module mult_tag_pipe
    import mult_arb_pkg::*;
#(
    parameter int unsigned DEPTH = 2
) (
    input  logic clk_i,
    input  logic rst_i,
    input  tag_t tag_i,
    output tag_t tag_o
);

    tag_t stage_q [DEPTH];

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            for (int unsigned i = 0; i < DEPTH; i++) stage_q[i] <= '0;
        end else begin
            stage_q[0] <= tag_i;
            for (int unsigned i = 1; i < DEPTH; i++) stage_q[i] <= stage_q[i-1];
        end
    end

    assign tag_o = stage_q[DEPTH-1];

endmodule

// File: rtl/mult_share_arbiter.sv
// Round-robin time-sharing of one fixed-latency multiplier between NREQ
// requesters. Optional completion counter enabled by MULT_ARB_STATS_EN.
module mult_share_arbiter
    import mult_arb_pkg::*;
#(
    parameter int unsigned NREQ     = 2,
    parameter int unsigned WIDTH    = 32,
    parameter int unsigned MULT_LAT = 1
) (
    input  logic                  wb_clk_i,
    input  logic                  wb_rst_i,
    input  logic [NREQ-1:0]       req_valid,
    output logic [NREQ-1:0]       req_ready,
    input  logic [NREQ*WIDTH-1:0] req_a,
    input  logic [NREQ*WIDTH-1:0] req_b,
    output logic [NREQ-1:0]       res_valid,
    input  logic [NREQ-1:0]       res_ready,
    output logic [NREQ*WIDTH-1:0] res_data,
    output logic [WIDTH-1:0]      mult_a,
    output logic [WIDTH-1:0]      mult_b,
    input  logic [WIDTH-1:0]      mult_product,
    output logic [15:0]           op_count
);

    logic [NREQ-1:0]       busy_q;
    logic [NREQ-1:0]       res_valid_q;
    logic [NREQ*WIDTH-1:0] res_data_q;
    logic [WIDTH-1:0]      mult_a_q, mult_b_q;
    logic [IDW-1:0]        rr_q;

    logic [NREQ-1:0]       eligible, res_hs;
    logic [IDW-1:0]        grant;
    logic                  accept;
    logic [WIDTH-1:0]      sel_a, sel_b;
    tag_t                  tag_in, tag_out;

    assign res_hs = res_valid_q & res_ready;

    // A requester stays ineligible in the cycle its result handshakes, since busy_q is still set.
    always_comb begin
        eligible  = req_valid & ~busy_q;
        grant     = '0;
        accept    = 1'b0;
        for (int unsigned off = 0; off < NREQ; off++) begin
            for (int unsigned i = 0; i < NREQ; i++) begin
                if (!accept && eligible[i] && ((32'(rr_q) + off) % NREQ == i)) begin
                    accept = 1'b1;
                    grant  = IDW'(i);
                end
            end
        end
        if (wb_rst_i) accept = 1'b0;
        req_ready = '0;
        sel_a     = '0;
        sel_b     = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (32'(grant) == i) begin
                req_ready[i] = accept;
                sel_a        = req_a[i*WIDTH +: WIDTH];
                sel_b        = req_b[i*WIDTH +: WIDTH];
            end
        end
        tag_in.vld = accept;
        tag_in.id  = grant;
    end

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            busy_q      <= '0;
            res_valid_q <= '0;
            res_data_q  <= '0;
            mult_a_q    <= '0;
            mult_b_q    <= '0;
            rr_q        <= '0;
        end else begin
            if (accept) begin
                mult_a_q <= sel_a;
                mult_b_q <= sel_b;
                rr_q     <= rr_next(grant, NREQ);
            end
            for (int unsigned i = 0; i < NREQ; i++) begin
                if (accept && 32'(grant) == i) busy_q[i] <= 1'b1;
                else if (res_hs[i])            busy_q[i] <= 1'b0;
                if (tag_out.vld && 32'(tag_out.id) == i) begin
                    res_valid_q[i]                <= 1'b1;
                    res_data_q[i*WIDTH +: WIDTH] <= mult_product;
                end else if (res_hs[i]) begin
                    res_valid_q[i] <= 1'b0;
                end
            end
        end
    end

    mult_tag_pipe #(.DEPTH(MULT_LAT + 1)) u_tag_pipe (
        .clk_i (wb_clk_i),
        .rst_i (wb_rst_i),
        .tag_i (tag_in),
        .tag_o (tag_out)
    );

`ifdef MULT_ARB_STATS_EN
    logic [15:0] op_count_q;

    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i)         op_count_q <= '0;
        else if (tag_out.vld) op_count_q <= op_count_q + 16'd1;
    end

    assign op_count = op_count_q;
`else
    assign op_count = '0;
`endif

    assign res_valid = res_valid_q;
    assign res_data  = res_data_q;
    assign mult_a    = mult_a_q;
    assign mult_b    = mult_b_q;

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Randomised scoreboard bench for mult_share_arbiter (3 requesters, 1-cycle multiplier).
module tb_mult_share_arbiter;

    localparam int unsigned N   = 3;
    localparam int unsigned W   = 32;
    localparam int unsigned LAT = 1;

    logic             clk = 1'b0;
    logic             wb_rst_i = 1'b1;
    logic [N-1:0]     req_valid = '0;
    logic [N-1:0]     req_ready;
    logic [N*W-1:0]   req_a = '0;
    logic [N*W-1:0]   req_b = '0;
    logic [N-1:0]     res_valid;
    logic [N-1:0]     res_ready = '0;
    logic [N*W-1:0]   res_data;
    logic [W-1:0]     mult_a, mult_b;
    logic [W-1:0]     mult_product = '0;
    logic [15:0]      op_count;

    always #5 clk = ~clk;

    // Behavioural single-cycle multiplier.
    always @(posedge clk) mult_product <= mult_a * mult_b;

    mult_share_arbiter #(.NREQ(N), .WIDTH(W), .MULT_LAT(LAT)) dut (
        .wb_clk_i     (clk),
        .wb_rst_i     (wb_rst_i),
        .req_valid    (req_valid),
        .req_ready    (req_ready),
        .req_a        (req_a),
        .req_b        (req_b),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_data     (res_data),
        .mult_a       (mult_a),
        .mult_b       (mult_b),
        .mult_product (mult_product),
        .op_count     (op_count)
    );

    typedef struct {
        logic [N-1:0] rdy;
        logic [N-1:0] vld;
        logic [W-1:0] ma;
        logic [W-1:0] mb;
        logic [15:0]  ops;
        bit           zero;
    } cyc_t;

    cyc_t         cyc_q[$];
    logic [W-1:0] prod_q[N][$];

    int checks   = 0;
    int failures = 0;

    // Reference model state: who is busy, who holds a result, when it is due.
    bit           m_busy[N];
    bit           m_vld[N];
    int           m_due[N];
    int           m_rr = 0;
    logic [W-1:0] m_ma = '0, m_mb = '0;
    logic [15:0]  m_ops = '0;
    int           prev_g = -1;
    bit           prev_hs[N];
    bit           prev_rst = 1'b1;
    logic [W-1:0] prev_a = '0, prev_b = '0;
    int           t = 0;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: actual=%0h expected=%0h", name, t, act, exp);
        end
    endtask

    task automatic do_cycle(input bit rst, input logic [N-1:0] v, input logic [N*W-1:0] a,
                            input logic [N*W-1:0] b, input logic [N-1:0] rr);
        cyc_t c;
        int   g;
        @(posedge clk);
        #1;
        t++;
        c.zero = prev_rst;
        if (prev_rst) begin
            for (int i = 0; i < N; i++) begin
                m_busy[i] = 0;
                m_vld[i]  = 0;
                prod_q[i].delete();
            end
            m_rr  = 0;
            m_ma  = '0;
            m_mb  = '0;
            m_ops = '0;
        end else begin
            for (int i = 0; i < N; i++)
                if (prev_hs[i]) begin
                    m_busy[i] = 0;
                    m_vld[i]  = 0;
                end
            if (prev_g >= 0) begin
                m_busy[prev_g] = 1;
                m_due[prev_g]  = t + 2;
                m_rr           = (prev_g + 1) % N;
                m_ma           = prev_a;
                m_mb           = prev_b;
            end
            for (int i = 0; i < N; i++)
                if (m_busy[i] && !m_vld[i] && m_due[i] == t) begin
                    m_vld[i] = 1;
                    m_ops++;
                end
        end

        wb_rst_i  = rst;
        req_valid = v;
        req_a     = a;
        req_b     = b;
        res_ready = rr;

        g = -1;
        if (!rst)
            for (int off = 0; off < N; off++) begin
                int idx;
                idx = (m_rr + off) % N;
                if (g < 0 && v[idx] && !m_busy[idx]) g = idx;
            end

        c.rdy = '0;
        c.vld = '0;
        for (int i = 0; i < N; i++) begin
            c.rdy[i] = (g == i);
            c.vld[i] = m_vld[i];
        end
        c.ma = m_ma;
        c.mb = m_mb;
`ifdef MULT_ARB_STATS_EN
        c.ops = m_ops;
`else
        c.ops = '0;
`endif
        cyc_q.push_back(c);

        if (g >= 0) begin
            prev_a = a[g*W +: W];
            prev_b = b[g*W +: W];
            prod_q[g].push_back(prev_a * prev_b);
        end
        for (int i = 0; i < N; i++) prev_hs[i] = m_vld[i] && rr[i] && !rst;
        prev_g   = g;
        prev_rst = rst;
    endtask

    function automatic logic [N*W-1:0] pk(input logic [W-1:0] x0, input logic [W-1:0] x1,
                                          input logic [W-1:0] x2);
        return {x2, x1, x0};
    endfunction

    // Monitor: per-cycle handshake/operand checks plus product scoreboard on each new result.
    initial begin : monitor
        cyc_t         c;
        bit           seen[N];
        logic [W-1:0] last[N];
        logic [W-1:0] got;
        for (int i = 0; i < N; i++) seen[i] = 0;
        forever begin
            @(negedge clk);
            if (cyc_q.size() != 0) begin
                c = cyc_q.pop_front();
                chk("req_ready", 128'(req_ready), 128'(c.rdy));
                chk("res_valid", 128'(res_valid), 128'(c.vld));
                chk("mult_a", 128'(mult_a), 128'(c.ma));
                chk("mult_b", 128'(mult_b), 128'(c.mb));
                chk("op_count", 128'(op_count), 128'(c.ops));
                if (c.zero) chk("res_data_reset", 128'(res_data), 128'(0));
                for (int i = 0; i < N; i++) begin
                    got = res_data[i*W +: W];
                    if (res_valid[i] && !seen[i]) begin
                        if (prod_q[i].size() == 0) begin
                            checks++;
                            failures++;
                            $display("FAIL unexpected_result req=%0d cycle %0d: actual=%0h expected=none", i, t, got);
                        end else begin
                            chk("res_data", 128'(got), 128'(prod_q[i].pop_front()));
                        end
                        last[i] = got;
                    end else if (res_valid[i]) begin
                        chk("res_data_hold", 128'(got), 128'(last[i]));
                    end
                    seen[i] = res_valid[i];
                end
            end
        end
    end

    initial begin : driver
        logic [N*W-1:0] a, b;
        logic [N-1:0]   v, rr;
        bit             rst;

        repeat (3) do_cycle(1, '0, '0, '0, '0);

        // Single op 3*5 on requester 0, then consume.
        do_cycle(0, 3'b001, pk(3, 0, 0), pk(5, 0, 0), '0);
        repeat (4) do_cycle(0, '0, '0, '0, '0);
        do_cycle(0, '0, '0, '0, 3'b001);
        repeat (2) do_cycle(0, '0, '0, '0, '0);

        // Contention between requesters 0 and 1.
        repeat (20) do_cycle(0, 3'b011, pk(7, 11, 0), pk(9, 13, 0), 3'b111);

        // Backpressure on requester 1.
        repeat (15) do_cycle(0, 3'b011, pk(21, 4, 0), pk(2, 6, 0), 3'b101);
        repeat (6) do_cycle(0, '0, '0, '0, 3'b111);

        // Pointer wrap: grant 1 -> pointer 2, then only requester 0 valid.
        do_cycle(0, 3'b010, pk(0, 8, 0), pk(0, 8, 0), 3'b111);
        do_cycle(0, 3'b001, pk(6, 0, 0), pk(7, 0, 0), 3'b111);
        do_cycle(0, 3'b110, pk(0, 2, 3), pk(0, 2, 3), 3'b111);
        repeat (6) do_cycle(0, '0, '0, '0, 3'b111);

        // Reset one cycle after accept, then a normal op.
        do_cycle(0, 3'b100, pk(0, 0, 9), pk(0, 0, 9), 3'b111);
        do_cycle(1, '0, '0, '0, 3'b111);
        repeat (5) do_cycle(0, '0, '0, '0, 3'b111);
        do_cycle(0, 3'b100, pk(0, 0, 12), pk(0, 0, 10), 3'b111);
        repeat (6) do_cycle(0, '0, '0, '0, 3'b111);

        for (int k = 0; k < 3000; k++) begin
            v  = N'($urandom);
            rr = N'($urandom);
            a  = {$urandom, $urandom, $urandom};
            b  = {$urandom, $urandom, $urandom};
            if ($urandom_range(0, 3) == 0) a = a & {N{32'h0000_00FF}};
            rst = ($urandom_range(0, 299) == 0);
            do_cycle(rst, v, a, b, rr);
        end

        repeat (10) do_cycle(0, '0, '0, '0, '1);
        @(negedge clk);
        @(negedge clk);
        for (int i = 0; i < N; i++) chk("drain_empty", 128'(prod_q[i].size()), 128'(0));
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
